// File: rtl/punc_arb_pkg.sv
// Shared definitions for the PUnC memory arbiter: requester IDs, sizes and
// the ownership FSM encoding (state value doubles as the visible owner ID).
package punc_arb_pkg;

   localparam int NUM_REQ      = 3;
   localparam int ADDR_W       = 16;
   localparam int DATA_W       = 16;
   localparam int LOCK_TIMEOUT = 8;

   localparam logic [1:0] FETCH      = 2'd0;
   localparam logic [1:0] DATA       = 2'd1;
   localparam logic [1:0] DEBUG      = 2'd2;
   localparam logic [1:0] OWNER_NONE = 2'd3;

   typedef enum logic [1:0] {
      ST_OWN_FETCH = 2'd0,
      ST_OWN_DATA  = 2'd1,
      ST_OWN_DEBUG = 2'd2,
      ST_IDLE      = 2'd3
   } arb_state_t;

   function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [1:0] id);
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      if (int'(id) < NUM_REQ)
         oh[id] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/punc_mem_arbiter_if.sv
// Requester and memory-side bus of the PUnC memory arbiter, one lane per
// requester (0 fetch, 1 data, 2 debug) plus the shared memory port.
interface punc_mem_arbiter_if;
   import punc_arb_pkg::*;

   logic [NUM_REQ-1:0]             req;
   logic [NUM_REQ-1:0]             we;
   logic [NUM_REQ-1:0]             lock;
   logic [NUM_REQ-1:0][ADDR_W-1:0] addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] wdata;
   logic [NUM_REQ-1:0]             gnt;
   logic [NUM_REQ-1:0]             rvalid;
   logic [DATA_W-1:0]              rdata;
   logic [ADDR_W-1:0]              mem_addr;
   logic [DATA_W-1:0]              mem_wdata;
   logic                           mem_we;
   logic [DATA_W-1:0]              mem_rdata;
   logic [1:0]                     owner;

   modport master (
      output req, we, lock, addr, wdata, mem_rdata,
      input  gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we, owner
   );

   modport slave (
      input  req, we, lock, addr, wdata, mem_rdata,
      output gnt, rvalid, rdata, mem_addr, mem_wdata, mem_we, owner
   );

endinterface

// File: rtl/punc_rr_picker.sv
// Combinational round-robin picker: the first active request after
// last_grant (wrapping 2 -> 0) wins, yielding a one-hot or zero grant.
module punc_rr_picker
   import punc_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         last_grant,
   output logic [NUM_REQ-1:0] gnt
);

   logic [1:0] cand;

   always_comb begin
      gnt  = '0;
      cand = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = 2'((int'(last_grant) + i) % NUM_REQ);
         if (gnt == '0 && req[cand])
            gnt[cand] = 1'b1;
      end
   end

endmodule

// File: rtl/punc_mem_arbiter.sv
// Single-port memory arbiter for PUnC: round-robin among fetch/data/debug,
// with lockable ownership for multi-access sequences and a lock timeout.
module punc_mem_arbiter
   import punc_arb_pkg::*;
(
   input logic               clk,
   input logic               rst,
   punc_mem_arbiter_if.slave bus
);

   arb_state_t         state;
   logic [1:0]         last_grant;
   logic [2:0]         idle_cnt;
   logic [NUM_REQ-1:0] rvalid_q;
   logic [NUM_REQ-1:0] rr_gnt;
   logic [NUM_REQ-1:0] gnt;
   logic [NUM_REQ-1:0] rvalid;
   logic [1:0]         gnt_id;
   logic               gnt_any;
   logic               owner_req;

   punc_rr_picker u_picker (
      .req        (bus.req),
      .last_grant (last_grant),
      .gnt        (rr_gnt)
   );

   // A locked owner is the only requester eligible; reset blocks every grant
   // so nothing issued during reset can return data later.
   always_comb begin
      gnt = '0;
      if (!rst) begin
         if (state == ST_IDLE)
            gnt = rr_gnt;
         else
            gnt = bus.req & id_to_onehot(2'(state));
      end
   end

   always_comb begin
      gnt_id = FETCH;
      if (gnt[DATA])
         gnt_id = DATA;
      if (gnt[DEBUG])
         gnt_id = DEBUG;
   end

   assign gnt_any   = |gnt;
   assign owner_req = |(bus.req & id_to_onehot(2'(state)));

   assign bus.gnt       = gnt;
   assign bus.mem_we    = gnt_any & bus.we[gnt_id];
   assign bus.mem_addr  = gnt_any ? bus.addr[gnt_id]  : '0;
   assign bus.mem_wdata = gnt_any ? bus.wdata[gnt_id] : '0;

   // Ownership FSM, lock timeout and read-return tags. The timeout counter
   // counts cycles without a request from the owner; the 8th releases it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         last_grant <= DEBUG;
         idle_cnt   <= '0;
         rvalid_q   <= '0;
      end else begin
         rvalid_q <= gnt & ~bus.we;
         if (gnt_any) begin
            last_grant <= gnt_id;
            idle_cnt   <= '0;
            if (state == ST_IDLE) begin
               if (bus.lock[gnt_id])
                  state <= arb_state_t'(gnt_id);
            end else if (!bus.lock[gnt_id]) begin
               state <= ST_IDLE;
            end
         end else if (state != ST_IDLE && !owner_req) begin
            if (idle_cnt == 3'(LOCK_TIMEOUT - 1)) begin
               state    <= ST_IDLE;
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + 3'd1;
            end
         end
      end
   end

   assign rvalid    = rst ? '0 : rvalid_q;
   assign bus.rvalid = rvalid;
   assign bus.rdata = (|rvalid) ? bus.mem_rdata : '0;
   assign bus.owner = rst ? OWNER_NONE : 2'(state);

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Self-checking bench for punc_mem_arbiter: directed scenarios plus random
// traffic, checked against a transaction-level reference model.
module tb_punc_mem_arbiter;
   import punc_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   punc_mem_arbiter_if bus ();

   punc_mem_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];

   always @(posedge clk) begin
      if (bus.mem_we)
         mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_addr];
   end

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model state: owner -1 means nobody holds the lock.
   int          m_owner    = -1;
   int          m_last     = 2;
   int          m_idle     = 0;
   bit          pend_valid = 1'b0;
   int          pend_k     = 0;
   logic [15:0] pend_data  = '0;

   int          exp_g;
   logic [2:0]  exp_gnt;
   logic [2:0]  exp_rvalid;
   logic [15:0] exp_rdata;
   logic [1:0]  exp_owner;
   logic        exp_mem_we;
   logic [15:0] exp_mem_addr;
   logic [15:0] exp_mem_wdata;

   task automatic drive_idle();
      bus.req   = '0;
      bus.we    = '0;
      bus.lock  = '0;
      bus.addr  = '0;
      bus.wdata = '0;
   endtask

   task automatic apply_stimulus(input int k, input logic w, input logic l,
                                 input logic [15:0] a, input logic [15:0] d);
      bus.req[k[1:0]]   = 1'b1;
      bus.we[k[1:0]]    = w;
      bus.lock[k[1:0]]  = l;
      bus.addr[k[1:0]]  = a;
      bus.wdata[k[1:0]] = d;
   endtask

   // Let inputs settle, then derive every expected output from the model.
   task automatic predict();
      int cand;
      #1;
      exp_g = -1;
      if (!rst) begin
         if (m_owner >= 0) begin
            if (bus.req[m_owner[1:0]]) exp_g = m_owner;
         end else begin
            for (int i = 1; i <= 3; i++) begin
               cand = (m_last + i) % 3;
               if (exp_g < 0 && bus.req[cand[1:0]]) exp_g = cand;
            end
         end
      end
      exp_gnt = '0;
      exp_mem_we = 1'b0;
      exp_mem_addr = '0;
      exp_mem_wdata = '0;
      if (exp_g >= 0) begin
         exp_gnt[exp_g[1:0]] = 1'b1;
         exp_mem_we    = bus.we[exp_g[1:0]];
         exp_mem_addr  = bus.addr[exp_g[1:0]];
         exp_mem_wdata = bus.wdata[exp_g[1:0]];
      end
      exp_rvalid = '0;
      exp_rdata  = '0;
      if (!rst && pend_valid) begin
         exp_rvalid[pend_k[1:0]] = 1'b1;
         exp_rdata = pend_data;
      end
      exp_owner = (rst || m_owner < 0) ? 2'd3 : m_owner[1:0];
   endtask

   task automatic advance();
      if (rst) begin
         m_owner = -1; m_last = 2; m_idle = 0; pend_valid = 1'b0;
      end else begin
         pend_valid = 1'b0;
         if (exp_g >= 0) begin
            if (bus.we[exp_g[1:0]]) begin
               ref_mem[bus.addr[exp_g[1:0]]] = bus.wdata[exp_g[1:0]];
            end else begin
               pend_valid = 1'b1;
               pend_k     = exp_g;
               pend_data  = ref_mem[bus.addr[exp_g[1:0]]];
            end
            m_last = exp_g;
            m_idle = 0;
            if (m_owner < 0) begin
               if (bus.lock[exp_g[1:0]]) m_owner = exp_g;
            end else if (!bus.lock[exp_g[1:0]]) begin
               m_owner = -1;
            end
         end else if (m_owner >= 0) begin
            m_idle++;
            if (m_idle == LOCK_TIMEOUT) begin
               m_owner = -1;
               m_idle  = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) apply_stimulus(k, 1'b0, 1'b0, 16'(k), '0);
      for (int c = 0; c < 3; c++) begin
         predict();
         n_compared++;
         if (bus.gnt !== 3'b000 || bus.mem_we !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_gnt: gnt=%b mem_we=%b, required 000/0", bus.gnt, bus.mem_we);
         end
         n_compared++;
         if (bus.rvalid !== 3'b000 || bus.rdata !== 16'h0000) begin
            n_mismatched++;
            $display("[TB] FAIL reset_rvalid: rvalid=%b rdata=%h, required 000/0000", bus.rvalid, bus.rdata);
         end
         n_compared++;
         if (bus.owner !== 2'd3) begin
            n_mismatched++;
            $display("[TB] FAIL reset_owner: owner=%0d, required 3", bus.owner);
         end
         advance();
      end
      rst = 1'b0;
      drive_idle();
   endtask

   task automatic test_round_robin();
      drive_idle();
      for (int k = 0; k < 3; k++) apply_stimulus(k, 1'b0, 1'b0, 16'h0010 * 16'(k + 1), '0);
      for (int c = 0; c < 4; c++) begin
         if (c == 3) drive_idle();
         predict();
         n_compared++;
         if (bus.gnt !== exp_gnt) begin
            n_mismatched++;
            $display("[TB] FAIL rr_gnt: cycle %0d gnt=%b, required %b", c, bus.gnt, exp_gnt);
         end
         if (c < 3) begin
            n_compared++;
            if (bus.gnt !== (3'b001 << c)) begin
               n_mismatched++;
               $display("[TB] FAIL rr_order: cycle %0d gnt=%b, required %b", c, bus.gnt, 3'b001 << c);
            end
         end
         n_compared++;
         if (bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata) begin
            n_mismatched++;
            $display("[TB] FAIL rr_rdata: cycle %0d rvalid=%b rdata=%h, required %b/%h",
                     c, bus.rvalid, bus.rdata, exp_rvalid, exp_rdata);
         end
         advance();
      end
   endtask

   task automatic test_write_read();
      drive_idle();
      apply_stimulus(1, 1'b1, 1'b0, 16'h0040, 16'hBEEF);
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin drive_idle(); apply_stimulus(0, 1'b0, 1'b0, 16'h0040, '0); end
         if (c == 2) drive_idle();
         predict();
         n_compared++;
         if (bus.gnt !== exp_gnt || bus.mem_we !== exp_mem_we || bus.mem_addr !== exp_mem_addr
             || bus.mem_wdata !== exp_mem_wdata) begin
            n_mismatched++;
            $display("[TB] FAIL wr_mem: cycle %0d gnt=%b we=%b addr=%h wdata=%h, required %b/%b/%h/%h", c,
                     bus.gnt, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_gnt, exp_mem_we, exp_mem_addr, exp_mem_wdata);
         end
         if (c == 2) begin
            n_compared++;
            if (bus.rvalid !== 3'b001 || bus.rdata !== 16'hBEEF) begin
               n_mismatched++;
               $display("[TB] FAIL wr_readback: rvalid=%b rdata=%h, required 001/beef", bus.rvalid, bus.rdata);
            end
         end
         advance();
      end
   endtask

   task automatic test_lock();
      logic [2:0] want_gnt [4];
      logic [1:0] want_own [4];
      want_gnt = '{3'b010, 3'b010, 3'b100, 3'b000};
      want_own = '{2'd3, 2'd1, 2'd3, 2'd3};
      drive_idle();
      apply_stimulus(1, 1'b0, 1'b1, 16'h3000, '0);
      apply_stimulus(2, 1'b0, 1'b0, 16'h0005, '0);
      for (int c = 0; c < 4; c++) begin
         if (c == 1) apply_stimulus(1, 1'b1, 1'b0, 16'h3001, 16'h1234);
         if (c == 2) bus.req[1] = 1'b0;
         if (c == 3) drive_idle();
         predict();
         n_compared++;
         if (bus.gnt !== want_gnt[c] || bus.gnt !== exp_gnt) begin
            n_mismatched++;
            $display("[TB] FAIL lock_gnt: cycle %0d gnt=%b, required %b", c, bus.gnt, want_gnt[c]);
         end
         n_compared++;
         if (bus.owner !== want_own[c] || bus.owner !== exp_owner) begin
            n_mismatched++;
            $display("[TB] FAIL lock_owner: cycle %0d owner=%0d, required %0d", c, bus.owner, want_own[c]);
         end
         n_compared++;
         if (bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata) begin
            n_mismatched++;
            $display("[TB] FAIL lock_rdata: cycle %0d rvalid=%b rdata=%h, required %b/%h",
                     c, bus.rvalid, bus.rdata, exp_rvalid, exp_rdata);
         end
         advance();
      end
   endtask

   task automatic test_timeout();
      drive_idle();
      apply_stimulus(1, 1'b0, 1'b1, 16'h0007, '0);
      for (int c = 0; c < 11; c++) begin
         if (c == 1) begin drive_idle(); apply_stimulus(0, 1'b0, 1'b0, 16'h0009, '0); end
         if (c == 10) drive_idle();
         predict();
         n_compared++;
         if (bus.gnt !== exp_gnt || bus.owner !== exp_owner) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_track: cycle %0d gnt=%b owner=%0d, required %b/%0d",
                     c, bus.gnt, bus.owner, exp_gnt, exp_owner);
         end
         if (c == 8 || c == 9) begin
            n_compared++;
            if (bus.gnt !== ((c == 9) ? 3'b001 : 3'b000) || bus.owner !== ((c == 9) ? 2'd3 : 2'd1)) begin
               n_mismatched++;
               $display("[TB] FAIL timeout_edge: idle cycle %0d gnt=%b owner=%0d", c, bus.gnt, bus.owner);
            end
         end
         n_compared++;
         if (bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata) begin
            n_mismatched++;
            $display("[TB] FAIL timeout_rdata: cycle %0d rvalid=%b rdata=%h, required %b/%h",
                     c, bus.rvalid, bus.rdata, exp_rvalid, exp_rdata);
         end
         advance();
      end
   endtask

   task automatic test_reset_mid_read();
      drive_idle();
      apply_stimulus(1, 1'b0, 1'b0, 16'h0011, '0);
      predict();
      advance();
      drive_idle();
      apply_stimulus(2, 1'b0, 1'b0, 16'h0022, '0);
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         if (c == 1) begin rst = 1'b0; drive_idle(); apply_stimulus(0, 1'b0, 1'b0, 16'h0033, '0); end
         if (c == 2) drive_idle();
         predict();
         n_compared++;
         if (bus.gnt !== exp_gnt || (c == 0 && bus.gnt !== 3'b000) || (c == 1 && bus.gnt !== 3'b001)) begin
            n_mismatched++;
            $display("[TB] FAIL rstread_gnt: cycle %0d gnt=%b, required %b", c, bus.gnt, exp_gnt);
         end
         n_compared++;
         if (bus.rvalid !== exp_rvalid || bus.rvalid[2] !== 1'b0 || bus.rdata !== exp_rdata) begin
            n_mismatched++;
            $display("[TB] FAIL rstread_rvalid: cycle %0d rvalid=%b rdata=%h, required %b/%h",
                     c, bus.rvalid, bus.rdata, exp_rvalid, exp_rdata);
         end
         advance();
      end
   endtask

   task automatic test_random();
      logic [2:0] prev_gnt = '0;
      int         waits [3] = '{0, 0, 0};
      drive_idle();
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < 3; k++) begin
            if (!bus.req[k] || prev_gnt[k]) begin
               bus.req[k]   = ($urandom_range(0, 99) < 60);
               bus.we[k]    = ($urandom_range(0, 2) == 0);
               bus.lock[k]  = ($urandom_range(0, 5) == 0);
               bus.addr[k]  = 16'($urandom_range(0, 31));
               bus.wdata[k] = 16'($urandom);
            end
         end
         predict();
         n_compared++;
         if (bus.gnt !== exp_gnt || !$onehot0(bus.gnt)) begin
            n_mismatched++;
            $display("[TB] FAIL rand_gnt: cycle %0d gnt=%b, required %b", c, bus.gnt, exp_gnt);
         end
         n_compared++;
         if (bus.mem_we !== exp_mem_we || bus.mem_addr !== exp_mem_addr || bus.mem_wdata !== exp_mem_wdata) begin
            n_mismatched++;
            $display("[TB] FAIL rand_mem: cycle %0d we=%b addr=%h wdata=%h, required %b/%h/%h",
                     c, bus.mem_we, bus.mem_addr, bus.mem_wdata, exp_mem_we, exp_mem_addr, exp_mem_wdata);
         end
         n_compared++;
         if (bus.rvalid !== exp_rvalid || bus.rdata !== exp_rdata) begin
            n_mismatched++;
            $display("[TB] FAIL rand_rdata: cycle %0d rvalid=%b rdata=%h, required %b/%h",
                     c, bus.rvalid, bus.rdata, exp_rvalid, exp_rdata);
         end
         n_compared++;
         if (bus.owner !== exp_owner) begin
            n_mismatched++;
            $display("[TB] FAIL rand_owner: cycle %0d owner=%0d, required %0d", c, bus.owner, exp_owner);
         end
         for (int k = 0; k < 3; k++) begin
            if (bus.gnt[k]) waits[k] = 0;
            else if (bus.req[k] && bus.gnt != 3'b000 && bus.owner == 2'd3) waits[k]++;
            else if (!bus.req[k]) waits[k] = 0;
         end
         n_compared++;
         if (waits[0] > 2 || waits[1] > 2 || waits[2] > 2) begin
            n_mismatched++;
            $display("[TB] FAIL rand_fair: cycle %0d waits=%0d/%0d/%0d, limit 2", c, waits[0], waits[1], waits[2]);
         end
         prev_gnt = exp_gnt;
         advance();
      end
      drive_idle();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 16'(i * 7 + 3);
         ref_mem[i] = 16'(i * 7 + 3);
      end
      drive_idle();
      @(posedge clk);
      #1;
      test_reset();
      test_round_robin();
      test_write_read();
      test_lock();
      test_timeout();
      test_reset_mid_read();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
